// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: stall/redirect controls in, fetch PC and status out.
// The execute/hazard side is the master; the PC generator is the slave.
interface fetch_pc_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  EN;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PCPlus4F;
  logic                  ValidF;
  logic                  MisalignF;
  logic [31:0]           FetchCount;
  logic [31:0]           RedirectCount;

  modport master (
    output EN, PCSrcE, PCTargetE,
    input  PCF, PCPlus4F, ValidF, MisalignF, FetchCount, RedirectCount
  );

  modport slave (
    input  EN, PCSrcE, PCTargetE,
    output PCF, PCPlus4F, ValidF, MisalignF, FetchCount, RedirectCount
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch program-counter generator: sequential/redirect select, stall hold and
// pending-redirect buffer. Optional perf counters built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_gen #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_gen_if.slave  pc_if
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_PEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic                  mis_q, mis_d;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_tgt;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    valid_d  = valid_q;
    mis_d    = 1'b0;
    load     = 1'b0;
    load_tgt = '0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        valid_d = 1'b1;
      end
      S_RUN: begin
        if (pc_if.EN) begin
          if (pc_if.PCSrcE) begin
            load     = 1'b1;
            load_tgt = pc_if.PCTargetE;
          end else begin
            pc_d = pc_q + DATA_WIDTH'(4);
          end
        end else if (pc_if.PCSrcE) begin
          pend_d  = pc_if.PCTargetE;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (pc_if.EN) begin
          // A redirect arriving on the release cycle is younger than the buffered one.
          load     = 1'b1;
          load_tgt = pc_if.PCSrcE ? pc_if.PCTargetE : pend_q;
          pend_d   = '0;
          state_d  = S_RUN;
        end else if (pc_if.PCSrcE) begin
          pend_d = pc_if.PCTargetE;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (load) begin
      pc_d  = {load_tgt[DATA_WIDTH-1:2], 2'b00};
      mis_d = |load_tgt[1:0];
    end
    pc4_d = pc_d + DATA_WIDTH'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      pc4_q   <= RESET_VECTOR + DATA_WIDTH'(4);
      pend_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_if.PCF       = pc_q;
  assign pc_if.PCPlus4F  = pc4_q;
  assign pc_if.ValidF    = valid_q;
  assign pc_if.MisalignF = mis_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic        adv;

  assign adv = (state_q != S_BOOT) && pc_if.EN;

  always_comb begin
    fcnt_d = fcnt_q + {31'd0, adv && valid_q};
    rcnt_d = rcnt_q + {31'd0, load};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign pc_if.FetchCount    = fcnt_q;
  assign pc_if.RedirectCount = rcnt_q;
`else
  assign pc_if.FetchCount    = 32'd0;
  assign pc_if.RedirectCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: directed test-plan sequences then random
// stall/redirect/reset traffic, checked against an abstract fetch model.
module tb_fetch_pc_gen;
  localparam int DW = 32;
  localparam logic [DW-1:0] RV = 32'h0000_0000;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
    logic          valid;
    logic          mis;
    logic [31:0]   fcnt;
    logic [31:0]   rcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_gen_if #(.DATA_WIDTH(DW)) bus ();

  fetch_pc_gen #(.DATA_WIDTH(DW), .RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_if (bus)
  );

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Abstract machine: a fetch address, a "just reset" flag and an optional
  // buffered redirect that is consumed by the next advancing cycle.
  logic [DW-1:0] m_pc = RV;
  logic          m_valid = 1'b0, m_mis = 1'b0, m_booting = 1'b1;
  logic          m_has_pend = 1'b0;
  logic [DW-1:0] m_pend = '0;
  logic [31:0]   m_fcnt = 0, m_rcnt = 0;

  task automatic model_load(input logic [DW-1:0] t);
    m_pc   = t & ~32'd3;
    m_mis  = (t % 4) != 0;
    m_rcnt = m_rcnt + 1;
  endtask

  task automatic model_edge(input logic r, e, s, input logic [DW-1:0] t);
    exp_t x;
    if (r) begin
      m_pc = RV; m_valid = 0; m_mis = 0; m_booting = 1;
      m_has_pend = 0; m_fcnt = 0; m_rcnt = 0;
    end else if (m_booting) begin
      m_booting = 0; m_valid = 1; m_mis = 0;
    end else if (e) begin
      m_mis = 0;
      if (s)               model_load(t);
      else if (m_has_pend) model_load(m_pend);
      else                 m_pc = m_pc + 4;
      m_has_pend = 0;
      m_fcnt = m_fcnt + 1;
    end else begin
      m_mis = 0;
      if (s) begin m_has_pend = 1; m_pend = t; end
    end
    x.pc = m_pc; x.pc4 = m_pc + 4; x.valid = m_valid; x.mis = m_mis;
`ifdef FETCH_PERF_CNT_EN
    x.fcnt = m_fcnt; x.rcnt = m_rcnt;
`else
    x.fcnt = 0; x.rcnt = 0;
`endif
    exp_q.push_back(x);
  endtask

  // Drive one cycle's inputs, let the edge happen, record the expectation.
  task automatic cyc(input logic r, e, s, input logic [DW-1:0] t);
    rst = r; bus.EN = e; bus.PCSrcE = s; bus.PCTargetE = t;
    @(posedge clk);
    model_edge(r, e, s, t);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("PCF",           bus.PCF,           e.pc);
        chk("PCPlus4F",      bus.PCPlus4F,      e.pc4);
        chk("ValidF",        {31'd0, bus.ValidF},    {31'd0, e.valid});
        chk("MisalignF",     {31'd0, bus.MisalignF}, {31'd0, e.mis});
        chk("FetchCount",    bus.FetchCount,    e.fcnt);
        chk("RedirectCount", bus.RedirectCount, e.rcnt);
      end
    end
  end

  initial begin : stim
    logic r, e, s;
    logic [DW-1:0] t;
    int waited;
    // Reset and boot, run up to PCF=0x10, redirect to 0x100.
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h100);
    repeat (2) cyc(0, 1, 0, 0);
    // Stalled redirect, overwrite in PEND, then same-cycle priority.
    cyc(0, 1, 1, 32'h20);
    cyc(0, 0, 1, 32'h200);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h300);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h200);
    cyc(0, 1, 1, 32'h400);
    // Misaligned target and wrap-around.
    cyc(0, 1, 1, 32'h103);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    repeat (2) cyc(0, 1, 0, 0);
    // Reset while a redirect is pending.
    cyc(0, 0, 1, 32'h500);
    cyc(1, 1, 1, 32'h600);
    repeat (3) cyc(0, 1, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 3) == 0);
      t = $urandom;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      cyc(r, e, s, t);
    end
    rst = 0; bus.EN = 0; bus.PCSrcE = 0; bus.PCTargetE = 0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 5) begin
      @(posedge clk); waited++;
    end
    @(negedge clk); #1;
    if (exp_q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
